// File: rtl/confreg_responder.sv
// Configuration-register responder on the data-SRAM port.
// Serves scratch registers, LEDs, seven-segment value, switches and a compare timer.
// Read data is registered and appears the cycle after the request, like a synchronous SRAM.
module confreg_responder #(
    parameter logic [31:0] CONF_BASE  = 32'hbfaf_0000,
    parameter logic        SIMULATION = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        conf_en,
    input  logic [3:0]  conf_wen,
    input  logic [31:0] conf_addr,
    input  logic [31:0] conf_wdata,
    output logic [31:0] conf_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_irq
);

    localparam logic [15:0] OffLed      = 16'hf000;
    localparam logic [15:0] OffTimer    = 16'hf010;
    localparam logic [15:0] OffTimerCmp = 16'hf014;
    localparam logic [15:0] OffIrqStat  = 16'hf018;
    localparam logic [15:0] OffIrqEn    = 16'hf01c;
    localparam logic [15:0] OffSwitch   = 16'hf020;
    localparam logic [15:0] OffNum      = 16'hf050;
    localparam logic [15:0] OffSimu     = 16'hfff0;

    // Replace only the byte lanes whose write enable is set.
    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  wen);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] cr_q [8];
    logic [31:0] cr_d [8];
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] timer_cmp_q, timer_cmp_d;
    logic        irq_status_q, irq_status_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] rdata_q, rdata_d;

    logic        hit;
    logic        wr;
    logic        rd;
    logic [15:0] offset;
    logic        is_cr;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        unused_addr_lsb;

    assign hit    = conf_en && (conf_addr[31:16] == CONF_BASE[31:16]);
    assign offset = {conf_addr[15:2], 2'b00};
    assign wr     = hit && (conf_wen != 4'b0000);
    assign rd     = conf_en && (conf_wen == 4'b0000);
    // 0x8000..0x801c share offset[15:5]
    assign is_cr  = (offset[15:5] == 11'h400);
    assign unused_addr_lsb = ^conf_addr[1:0];

    // Current register value at the decoded offset; also the base for byte-lane merges.
    always_comb begin
        rd_val = '0;
        if (is_cr) begin
            rd_val = cr_q[offset[4:2]];
        end else begin
            case (offset)
                OffLed:      rd_val = {16'h0000, led_q};
                OffTimer:    rd_val = timer_q;
                OffTimerCmp: rd_val = timer_cmp_q;
                OffIrqStat:  rd_val = {31'b0, irq_status_q};
                OffIrqEn:    rd_val = {31'b0, irq_en_q};
                OffSwitch:   rd_val = {24'h000000, sw_sync_q};
                OffNum:      rd_val = num_q;
                OffSimu:     rd_val = {31'b0, SIMULATION};
                default:     rd_val = '0;
            endcase
        end
    end

    assign wr_val = merge(rd_val, conf_wdata, conf_wen);

    // Next-state for all registers: writes, timer count, compare flag, read data capture.
    always_comb begin
        cr_d         = cr_q;
        led_d        = led_q;
        num_d        = num_q;
        timer_d      = timer_q + 32'd1;
        timer_cmp_d  = timer_cmp_q;
        irq_status_d = irq_status_q;
        irq_en_d     = irq_en_q;
        rdata_d      = rdata_q;

        if (rd) rdata_d = hit ? rd_val : 32'h0;

        if (wr) begin
            if (is_cr) begin
                cr_d[offset[4:2]] = wr_val;
            end else begin
                case (offset)
                    OffLed:      led_d       = wr_val[15:0];
                    OffTimer:    timer_d     = wr_val;
                    OffTimerCmp: timer_cmp_d = wr_val;
                    OffIrqStat:  if (conf_wen[0] && conf_wdata[0]) irq_status_d = 1'b0;
                    OffIrqEn:    if (conf_wen[0]) irq_en_d = conf_wdata[0];
                    OffNum:      num_d       = wr_val;
                    default:     ;
                endcase
            end
        end

        // A match in the same cycle as a clear takes priority.
        if (timer_q == timer_cmp_q) irq_status_d = 1'b1;
    end

    // State registers with synchronous reset; switches pass through a two-flop synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) cr_q[i] <= '0;
            led_q        <= 16'hffff;
            num_q        <= '0;
            timer_q      <= '0;
            timer_cmp_q  <= 32'hffff_ffff;
            irq_status_q <= 1'b0;
            irq_en_q     <= 1'b0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            rdata_q      <= '0;
        end else begin
            cr_q         <= cr_d;
            led_q        <= led_d;
            num_q        <= num_d;
            timer_q      <= timer_d;
            timer_cmp_q  <= timer_cmp_d;
            irq_status_q <= irq_status_d;
            irq_en_q     <= irq_en_d;
            sw_meta_q    <= switch_in;
            sw_sync_q    <= sw_meta_q;
            rdata_q      <= rdata_d;
        end
    end

    assign conf_rdata = rdata_q;
    assign led        = led_q;
    assign num_data   = num_q;
    assign timer_irq  = irq_status_q & irq_en_q;

endmodule

// File: tb/tb_confreg_responder.sv
// Self-checking bench for confreg_responder: directed scenarios plus randomized traffic
// compared against a register-map reference model.
module tb_confreg_responder;

    localparam logic [31:0] Base = 32'hbfaf_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_irq;

    int checks = 0;
    int failures = 0;

    confreg_responder dut (
        .clk        (clk),
        .reset      (reset),
        .conf_en    (conf_en),
        .conf_wen   (conf_wen),
        .conf_addr  (conf_addr),
        .conf_wdata (conf_wdata),
        .conf_rdata (conf_rdata),
        .switch_in  (switch_in),
        .led        (led),
        .num_data   (num_data),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_cr [8];
    logic [15:0] m_led;
    logic [31:0] m_num, m_timer, m_cmp, m_rdata;
    logic        m_irq, m_en;
    logic [7:0]  m_s1, m_s2;

    function automatic logic [31:0] m_read(input logic [15:0] off);
        if (off >= 16'h8000 && off <= 16'h801c) return m_cr[off[4:2]];
        case (off)
            16'hf000: return {16'h0, m_led};
            16'hf010: return m_timer;
            16'hf014: return m_cmp;
            16'hf018: return {31'b0, m_irq};
            16'hf01c: return {31'b0, m_en};
            16'hf020: return {24'h0, m_s2};
            16'hf050: return m_num;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] rv, nv;
        logic [15:0] off;
        logic        hit, match;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_cr[i] = 0;
            m_led = 16'hffff; m_num = 0; m_timer = 0; m_cmp = 32'hffff_ffff;
            m_irq = 0; m_en = 0; m_s1 = 0; m_s2 = 0; m_rdata = 0;
        end else begin
            hit   = conf_en && (conf_addr[31:16] == 16'hbfaf);
            off   = {conf_addr[15:2], 2'b00};
            rv    = m_read(off);
            match = (m_timer == m_cmp);
            if (conf_en && conf_wen == 4'h0) m_rdata = hit ? rv : 32'h0;
            m_timer = m_timer + 1;
            if (hit && conf_wen != 4'h0) begin
                nv = rv;
                for (int i = 0; i < 4; i++) if (conf_wen[i]) nv[8*i +: 8] = conf_wdata[8*i +: 8];
                if (off >= 16'h8000 && off <= 16'h801c) m_cr[off[4:2]] = nv;
                else case (off)
                    16'hf000: m_led = nv[15:0];
                    16'hf010: m_timer = nv;
                    16'hf014: m_cmp = nv;
                    16'hf018: if (conf_wen[0] && conf_wdata[0]) m_irq = 0;
                    16'hf01c: if (conf_wen[0]) m_en = conf_wdata[0];
                    16'hf050: m_num = nv;
                    default: ;
                endcase
            end
            if (match) m_irq = 1;
            m_s2 = m_s1;
            m_s1 = switch_in;
        end
    endtask

    // Apply one request for one clock; model advances on the same edge; returns #1 after it.
    task automatic do_cycle(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata);
        conf_en = en; conf_wen = wen; conf_addr = addr; conf_wdata = wdata;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 4'h0, Base + 32'hf000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=%h", conf_rdata, 32'h0);
        end
        checks++;
        if (led !== 16'hffff) begin
            failures++; $display("FAIL reset_led got=%h exp=%h", led, 16'hffff);
        end
        checks++;
        if (num_data !== 32'h0 || timer_irq !== 1'b0) begin
            failures++; $display("FAIL reset_num_irq got=%h/%b exp=0/0", num_data, timer_irq);
        end
        reset = 1'b0;
        do_cycle(1'b1, 4'h0, Base + 32'hf000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0000_ffff) begin
            failures++; $display("FAIL reset_read_led got=%h exp=%h", conf_rdata, 32'h0000_ffff);
        end
        do_cycle(1'b1, 4'h0, Base + 32'hf014, 32'h0);
        checks++;
        if (conf_rdata !== 32'hffff_ffff) begin
            failures++; $display("FAIL reset_read_cmp got=%h exp=%h", conf_rdata, 32'hffff_ffff);
        end
        do_cycle(1'b1, 4'h0, Base + 32'h8000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_read_cr0 got=%h exp=%h", conf_rdata, 32'h0);
        end
    endtask

    task automatic test_byte_write();
        do_cycle(1'b1, 4'hf, Base + 32'h800c, 32'h1234_5678);
        do_cycle(1'b1, 4'hc, Base + 32'h800c, 32'haa55_0000);
        do_cycle(1'b1, 4'h0, Base + 32'h800c, 32'h0);
        checks++;
        if (conf_rdata !== 32'haa55_5678) begin
            failures++; $display("FAIL byte_write got=%h exp=%h", conf_rdata, 32'haa55_5678);
        end
        do_cycle(1'b1, 4'h3, Base + 32'hf000, 32'hbeef_1234);
        do_cycle(1'b1, 4'h0, Base + 32'hf000, 32'h0);
        checks++;
        if (led !== 16'h1234 || conf_rdata !== 32'h0000_1234) begin
            failures++; $display("FAIL led_write got=%h/%h exp=1234/00001234", led, conf_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 4'hf, Base + 32'h8000, 32'h1);
        do_cycle(1'b1, 4'hf, Base + 32'h8004, 32'h2);
        do_cycle(1'b1, 4'h0, Base + 32'h8000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h1) begin
            failures++; $display("FAIL b2b_first got=%h exp=%h", conf_rdata, 32'h1);
        end
        do_cycle(1'b1, 4'h0, Base + 32'h8004, 32'h0);
        checks++;
        if (conf_rdata !== 32'h2) begin
            failures++; $display("FAIL b2b_second got=%h exp=%h", conf_rdata, 32'h2);
        end
        do_cycle(1'b0, 4'h0, Base + 32'h8000, 32'h0);
        do_cycle(1'b1, 4'hf, Base + 32'h8008, 32'h77);
        checks++;
        if (conf_rdata !== 32'h2) begin
            failures++; $display("FAIL b2b_hold got=%h exp=%h", conf_rdata, 32'h2);
        end
    endtask

    task automatic test_timer();
        do_cycle(1'b1, 4'hf, Base + 32'hf010, 32'hffff_fffe);
        do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 4'h0, Base + 32'hf010, 32'h0);
        checks++;
        if (conf_rdata !== 32'hffff_ffff) begin
            failures++; $display("FAIL timer_t2 got=%h exp=%h", conf_rdata, 32'hffff_ffff);
        end
        do_cycle(1'b1, 4'h0, Base + 32'hf010, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL timer_wrap got=%h exp=%h", conf_rdata, 32'h0);
        end
    endtask

    task automatic test_irq();
        do_cycle(1'b1, 4'hf, Base + 32'hf010, 32'h100);
        do_cycle(1'b1, 4'hf, Base + 32'hf014, 32'h10);
        do_cycle(1'b1, 4'h1, Base + 32'hf01c, 32'h1);
        do_cycle(1'b1, 4'h1, Base + 32'hf018, 32'h1);
        do_cycle(1'b1, 4'hf, Base + 32'hf010, 32'h0);
        for (int n = 1; n <= 17; n++) begin
            do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
            checks++;
            if (timer_irq !== (n >= 17)) begin
                failures++;
                $display("FAIL irq_rise n=%0d got=%b exp=%b", n, timer_irq, (n >= 17));
            end
        end
        do_cycle(1'b1, 4'h1, Base + 32'hf018, 32'h1);
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++; $display("FAIL irq_w1c got=%b exp=0", timer_irq);
        end
        do_cycle(1'b1, 4'hf, Base + 32'hf010, 32'h10);
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++; $display("FAIL irq_pre_coincide got=%b exp=0", timer_irq);
        end
        do_cycle(1'b1, 4'h1, Base + 32'hf018, 32'h1);
        checks++;
        if (timer_irq !== 1'b1) begin
            failures++; $display("FAIL irq_set_wins got=%b exp=1", timer_irq);
        end
        do_cycle(1'b1, 4'h0, Base + 32'hf018, 32'h0);
        checks++;
        if (conf_rdata !== 32'h1 || timer_irq !== 1'b1) begin
            failures++; $display("FAIL irq_sticky got=%h/%b exp=1/1", conf_rdata, timer_irq);
        end
    endtask

    task automatic test_decode();
        do_cycle(1'b1, 4'h0, 32'hbfb0_8000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL decode_miss_read got=%h exp=0", conf_rdata);
        end
        do_cycle(1'b1, 4'hf, 32'hbfb0_8000, 32'hdead_beef);
        do_cycle(1'b1, 4'hf, 32'hbfaf_1234, 32'hcafe_f00d);
        do_cycle(1'b1, 4'hf, Base + 32'hf020, 32'hffff_ffff);
        do_cycle(1'b1, 4'h0, 32'hbfaf_1234, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL decode_unmapped_read got=%h exp=0", conf_rdata);
        end
        do_cycle(1'b1, 4'h0, Base + 32'h8000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h1) begin
            failures++; $display("FAIL decode_no_write got=%h exp=%h", conf_rdata, 32'h1);
        end
        do_cycle(1'b1, 4'h0, Base + 32'hfff0, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL simu_flag got=%h exp=0", conf_rdata);
        end
    endtask

    task automatic test_switch();
        switch_in = 8'h00;
        do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        switch_in = 8'h5a;
        do_cycle(1'b1, 4'h0, Base + 32'hf020, 32'h0);
        do_cycle(1'b1, 4'h0, Base + 32'hf020, 32'h0);
        do_cycle(1'b1, 4'h0, Base + 32'hf020, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0000_005a) begin
            failures++; $display("FAIL switch_sync got=%h exp=%h", conf_rdata, 32'h5a);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 17))
            0, 1, 2, 3: return Base + 32'h8000 + 32'($urandom_range(0, 7) * 4);
            4:  return Base + 32'hf000;
            5:  return Base + 32'hf010;
            6:  return Base + 32'hf014;
            7:  return Base + 32'hf018;
            8:  return Base + 32'hf01c;
            9:  return Base + 32'hf020;
            10: return Base + 32'hf050;
            11: return Base + 32'hfff0;
            12: return Base + 32'hf004;
            13: return 32'hbfb0_8000 + 32'($urandom_range(0, 7) * 4);
            14: return Base + 32'hf000 + 32'($urandom_range(0, 3));
            default: return Base + 32'h8000 + 32'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic test_random();
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr, wdata;
        for (int k = 0; k < 400; k++) begin
            en    = ($urandom_range(0, 9) < 8);
            wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            addr  = pick_addr();
            wdata = $urandom;
            if ($urandom_range(0, 15) == 0) switch_in = 8'($urandom);
            do_cycle(en, wen, addr, wdata);
            checks++;
            if (conf_rdata !== m_rdata) begin
                failures++;
                $display("FAIL rand_rdata k=%0d addr=%h got=%h exp=%h", k, addr, conf_rdata, m_rdata);
            end
            checks++;
            if (led !== m_led || num_data !== m_num) begin
                failures++;
                $display("FAIL rand_regs k=%0d got=%h/%h exp=%h/%h", k, led, num_data, m_led, m_num);
            end
            checks++;
            if (timer_irq !== (m_irq & m_en)) begin
                failures++;
                $display("FAIL rand_irq k=%0d got=%b exp=%b", k, timer_irq, m_irq & m_en);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b1, 4'hf, Base + 32'h8000, 32'hdead_beef);
        do_cycle(1'b1, 4'h0, Base + 32'h8000, 32'h0);
        reset = 1'b1;
        do_cycle(1'b1, 4'h0, Base + 32'h8000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0 || led !== 16'hffff || timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%h/%h/%b exp=0/ffff/0", conf_rdata, led, timer_irq);
        end
        reset = 1'b0;
        do_cycle(1'b1, 4'h0, Base + 32'h8000, 32'h0);
        checks++;
        if (conf_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_mid_cr0 got=%h exp=0", conf_rdata);
        end
    endtask

    initial begin
        reset = 1'b1; conf_en = 1'b0; conf_wen = 4'h0; conf_addr = 32'h0; conf_wdata = 32'h0;
        switch_in = 8'h00;
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_timer();
        test_irq();
        test_decode();
        test_switch();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
